// File: rtl/pheapTypes.sv
// Shared pipelined-heap types: depth, top-level opcodes and completion codes.
package pheapTypes;

    localparam int unsigned LEVELS = 4;

    typedef enum logic {
        LEQ = 1'b0,
        DEQ = 1'b1
    } opcode_t;

    typedef enum logic [1:0] {
        WAIT       = 2'd0,
        DONE       = 2'd1,
        NEXT_LEVEL = 2'd2
    } done_t;

endpackage

// File: rtl/pheap_sched.sv
// Two-requester round-robin command scheduler in front of the pheap top level.
// Tracks occupancy to reject overflow/underflow locally and spaces heap starts.
module pheap_sched #(
    parameter int unsigned LEVELS  = pheapTypes::LEVELS,
    parameter int unsigned MIN_GAP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic                req0_deq,
    input  logic [31:0]         req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic                req1_deq,
    input  logic [31:0]         req1_data,
    output logic                req1_ready,
    output logic                resp_valid,
    output logic                resp_id,
    output logic                resp_ok,
    output logic [31:0]         resp_data,
    output logic                start,
    output pheapTypes::opcode_t op,
    output logic [31:0]         in,
    input  pheapTypes::done_t   done,
    input  logic [31:0]         out,
    output logic [LEVELS-1:0]   count,
    output logic                full,
    output logic                empty
);
    import pheapTypes::*;

    localparam int unsigned CAP = (1 << LEVELS) - 1;
    localparam int unsigned GW  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP,
        S_GAP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last;
    logic                r_id;
    logic                r_deq;
    logic                r_ok;
    logic [31:0]         r_data;
    logic [31:0]         r_out;
    logic [LEVELS-1:0]   r_count;
    logic [GW-1:0]       r_gap;

    logic                w_idle;
    logic                w_pick0;
    logic                w_pick1;
    logic                w_accept;
    logic                w_acc_deq;
    logic [31:0]         w_acc_data;
    logic                w_reject;
    logic                w_hold;
    logic                w_heap_done;

    // Round robin: on a tie the requester not served last wins.
    assign w_idle      = (r_state == S_IDLE) && !rst;
    assign w_pick1     = req1_valid && (!req0_valid || !r_last);
    assign w_pick0     = req0_valid && !w_pick1;
    assign w_accept    = w_idle && (req0_valid || req1_valid);
    assign w_acc_deq   = w_pick1 ? req1_deq  : req0_deq;
    assign w_acc_data  = w_pick1 ? req1_data : req0_data;
    assign w_reject    = w_acc_deq ? empty : full;
    assign w_hold      = (r_state == S_ISSUE) || (r_state == S_CAPTURE);
    assign w_heap_done = (r_state == S_CAPTURE) && (done != WAIT);

    assign req0_ready = w_accept && w_pick0;
    assign req1_ready = w_accept && w_pick1;

    assign start      = (r_state == S_ISSUE);
    assign op         = w_hold ? opcode_t'(r_deq) : LEQ;
    assign in         = w_hold ? r_data : 32'd0;
    assign resp_valid = (r_state == S_RESP);
    assign resp_id    = resp_valid && r_id;
    assign resp_ok    = resp_valid && r_ok;
    assign resp_data  = resp_valid ? r_out : 32'd0;
    assign count      = r_count;
    assign full       = (r_count == LEVELS'(CAP));
    assign empty      = (r_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_reject ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (done != WAIT) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = ((MIN_GAP != 0) && r_ok) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (r_gap <= GW'(1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latch, occupancy and spacing counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_deq   <= 1'b0;
            r_ok    <= 1'b0;
            r_data  <= 32'd0;
            r_out   <= 32'd0;
            r_count <= '0;
            r_gap   <= '0;
        end else begin
            if (w_accept) begin
                r_last <= w_pick1;
                r_id   <= w_pick1;
                r_deq  <= w_acc_deq;
                r_data <= w_acc_deq ? 32'd0 : w_acc_data;
                r_ok   <= !w_reject;
                r_out  <= 32'd0;
                if (!w_reject) begin
                    r_count <= w_acc_deq ? r_count - LEVELS'(1) : r_count + LEVELS'(1);
                end
            end
            if (w_heap_done && r_deq) begin
                r_out <= out;
            end
            if (r_state == S_RESP) begin
                r_gap <= GW'(MIN_GAP);
            end else if (r_state == S_GAP) begin
                r_gap <= r_gap - GW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pheap_sched.sv
// Directed bench for pheap_sched with a behavioural max-heap behind the top level.
module tb_pheap_sched;
    import pheapTypes::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req0_deq = 1'b0;
    logic [31:0] req0_data = 32'd0;
    logic        req0_ready;
    logic        req1_valid = 1'b0, req1_deq = 1'b0;
    logic [31:0] req1_data = 32'd0;
    logic        req1_ready;
    logic        resp_valid, resp_id, resp_ok;
    logic [31:0] resp_data;
    logic        start;
    opcode_t     op;
    logic [31:0] heap_in;
    done_t       done = WAIT;
    logic [31:0] heap_out = 32'd0;
    logic [3:0]  count;
    logic        full, empty;

    pheap_sched #(.LEVELS(4), .MIN_GAP(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_deq(req0_deq), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_deq(req1_deq), .req1_data(req1_data), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_ok(resp_ok), .resp_data(resp_data),
        .start(start), .op(op), .in(heap_in), .done(done), .out(heap_out),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    int extra_wait = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Heap model: max-first, completes the cycle after start plus extra_wait cycles.
    logic [31:0] heap_q[$];
    logic        hm_pend = 1'b0;
    int          hm_left = 0;

    function automatic logic [31:0] pop_max();
        int bi = 0;
        logic [31:0] v;
        if (heap_q.size() == 0) return 32'd0;
        for (int i = 1; i < heap_q.size(); i++) if (heap_q[i] > heap_q[bi]) bi = i;
        v = heap_q[bi];
        heap_q.delete(bi);
        return v;
    endfunction

    always @(posedge clk) begin
        done <= WAIT;
        if (rst) begin
            heap_q.delete();
            hm_pend  <= 1'b0;
            heap_out <= 32'd0;
        end else if (start) begin
            if (op == LEQ) begin
                heap_q.push_back(heap_in);
                heap_out <= 32'd0;
            end else begin
                heap_out <= pop_max();
            end
            if (extra_wait == 0) done <= (op == DEQ) ? NEXT_LEVEL : DONE;
            else begin
                hm_pend <= 1'b1;
                hm_left <= extra_wait;
            end
        end else if (hm_pend) begin
            hm_left <= hm_left - 1;
            if (hm_left == 1) begin
                done    <= DONE;
                hm_pend <= 1'b0;
            end
        end
    end

    // Monitors
    int          st_cyc[$];
    logic [31:0] st_in[$];
    logic        st_deq[$];
    int          rs_cyc[$];
    logic        rs_id[$];
    logic        rs_ok[$];
    logic [31:0] rs_data[$];
    int          g_id[$];
    int          g_cyc[$];

    always @(negedge clk) begin
        if (start === 1'b1) begin
            st_cyc.push_back(cyc);
            st_in.push_back(heap_in);
            st_deq.push_back(op == DEQ);
        end
        if (resp_valid === 1'b1) begin
            rs_cyc.push_back(cyc);
            rs_id.push_back(resp_id);
            rs_ok.push_back(resp_ok);
            rs_data.push_back(resp_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        extra_wait = 0;
        repeat (2) @(negedge clk);
        #1;
        st_cyc.delete(); st_in.delete(); st_deq.delete();
        rs_cyc.delete(); rs_id.delete(); rs_ok.delete(); rs_data.delete();
        g_id.delete(); g_cyc.delete();
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Present one command and hold it until accepted; acc = cycle index of the accepted command's first state.
    task automatic send(input int n, input bit deq, input logic [31:0] d, output int acc);
        bit got = 1'b0;
        acc = -1;
        if (n == 0) begin req0_valid = 1'b1; req0_deq = deq; req0_data = d; end
        else        begin req1_valid = 1'b1; req1_deq = deq; req1_data = d; end
        for (int k = 0; k < 100 && !got; k++) begin
            #1;
            if ((n == 0) ? req0_ready : req1_ready) begin
                acc = cyc + 1;
                got = 1'b1;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!got) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_resp(input int k);
        for (int i = 0; i < 200 && rs_cyc.size() < k; i++) begin
            @(negedge clk);
            #1;
        end
        if (rs_cyc.size() < k) check("resp_timeout", 32'(rs_cyc.size()), 32'(k));
    endtask

    // Both requesters valid until each has had its quota accepted.
    task automatic arb(input int n0, input int n1, input bit deq, input logic [31:0] base);
        int left0 = n0;
        int left1 = n1;
        for (int k = 0; k < 300 && (left0 > 0 || left1 > 0); k++) begin
            req0_valid = (left0 > 0); req0_deq = deq; req0_data = base + 32'(g_id.size());
            req1_valid = (left1 > 0); req1_deq = deq; req1_data = base + 32'(g_id.size());
            #1;
            if (req0_ready) begin g_id.push_back(0); g_cyc.push_back(cyc + 1); left0--; end
            if (req1_ready) begin g_id.push_back(1); g_cyc.push_back(cyc + 1); left1--; end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("arb_left", 32'(left0 + left1), 32'd0);
    endtask

    initial begin
        int a, a2, c;

        // Reset values, readies suppressed while rst is high
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_ok", 32'(resp_ok), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_in", heap_in, 32'd0);
        check("rst_op", 32'(op), 32'(LEQ));

        // Single ENQ 0x10 from requester 0
        do_reset();
        send(0, 1'b0, 32'h10, a);
        #1;
        check("enq_start", 32'(start), 32'd1);
        check("enq_issue_in", heap_in, 32'h10);
        @(negedge clk); #1;
        check("enq_capture_in", heap_in, 32'h10);
        check("enq_capture_start", 32'(start), 32'd0);
        wait_resp(1);
        check("enq_nstart", 32'(st_cyc.size()), 32'd1);
        check("enq_start_cyc", 32'(st_cyc[0]), 32'(a));
        check("enq_start_op", 32'(st_deq[0]), 32'd0);
        check("enq_start_in", st_in[0], 32'h10);
        check("enq_resp_cyc", 32'(rs_cyc[0]), 32'(a + 2));
        check("enq_resp_id", 32'(rs_id[0]), 32'd0);
        check("enq_resp_ok", 32'(rs_ok[0]), 32'd1);
        check("enq_resp_data", rs_data[0], 32'd0);
        check("enq_count", 32'(count), 32'd1);
        check("enq_empty", 32'(empty), 32'd0);

        // Both DEQ on empty: both rejected, requester 0 first
        do_reset();
        arb(1, 1, 1'b1, 32'd0);
        wait_resp(2);
        check("rej_g0", 32'(g_id[0]), 32'd0);
        check("rej_g1", 32'(g_id[1]), 32'd1);
        check("rej_spacing", 32'(g_cyc[1] - g_cyc[0]), 32'd2);
        check("rej_resp0_cyc", 32'(rs_cyc[0]), 32'(g_cyc[0]));
        check("rej_resp0_id", 32'(rs_id[0]), 32'd0);
        check("rej_resp0_ok", 32'(rs_ok[0]), 32'd0);
        check("rej_resp0_data", rs_data[0], 32'd0);
        check("rej_resp1_id", 32'(rs_id[1]), 32'd1);
        check("rej_resp1_ok", 32'(rs_ok[1]), 32'd0);
        check("rej_nstart", 32'(st_cyc.size()), 32'd0);
        check("rej_count", 32'(count), 32'd0);

        // Fill to capacity, then overflow is rejected
        do_reset();
        for (int v = 1; v <= 15; v++) send(0, 1'b0, 32'(v), a);
        #1;
        check("fill_count", 32'(count), 32'd15);
        check("fill_full", 32'(full), 32'd1);
        send(1, 1'b0, 32'h99, a);
        wait_resp(16);
        check("ovf_ok", 32'(rs_ok[15]), 32'd0);
        check("ovf_id", 32'(rs_id[15]), 32'd1);
        check("ovf_resp_cyc", 32'(rs_cyc[15]), 32'(a));
        check("ovf_last_ok", 32'(rs_ok[14]), 32'd1);
        check("ovf_nstart", 32'(st_cyc.size()), 32'd15);
        check("ovf_count", 32'(count), 32'd15);
        check("ovf_full", 32'(full), 32'd1);

        // ENQ 5, 9, 3 then three DEQs return max-first
        do_reset();
        send(0, 1'b0, 32'd5, a);
        send(0, 1'b0, 32'd9, a);
        send(0, 1'b0, 32'd3, a);
        for (int i = 0; i < 3; i++) send(1, 1'b1, 32'd0, a);
        wait_resp(6);
        check("deq_data0", rs_data[3], 32'd9);
        check("deq_data1", rs_data[4], 32'd5);
        check("deq_data2", rs_data[5], 32'd3);
        check("deq_ok", 32'(rs_ok[5]), 32'd1);
        check("deq_id", 32'(rs_id[5]), 32'd1);
        check("deq_empty", 32'(empty), 32'd1);
        check("deq_count", 32'(count), 32'd0);

        // Continuous contention: alternation and start spacing
        do_reset();
        arb(2, 2, 1'b0, 32'h100);
        wait_resp(4);
        check("rr_g0", 32'(g_id[0]), 32'd0);
        check("rr_g1", 32'(g_id[1]), 32'd1);
        check("rr_g2", 32'(g_id[2]), 32'd0);
        check("rr_g3", 32'(g_id[3]), 32'd1);
        for (int i = 1; i < 4; i++) check("rr_start_gap", 32'(st_cyc[i] - st_cyc[i-1]), 32'd5);
        check("rr_count", 32'(count), 32'd4);

        // Two extra WAIT cycles delay the response by two
        extra_wait = 2;
        send(0, 1'b0, 32'h77, a);
        wait_resp(5);
        check("wait_resp_cyc", 32'(rs_cyc[4] - a), 32'd4);
        check("wait_resp_ok", 32'(rs_ok[4]), 32'd1);
        check("wait_count", 32'(count), 32'd5);

        // Reset during CAPTURE aborts the command
        do_reset();
        extra_wait = 5;
        send(0, 1'b0, 32'h55, a);
        @(negedge clk); #1;
        check("abort_capture_in", heap_in, 32'h55);
        check("abort_capture_count", 32'(count), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        extra_wait = 0;
        c = cyc;
        send(0, 1'b0, 32'h66, a2);
        check("abort_no_resp", 32'(rs_cyc.size()), 32'd0);
        check("abort_accept_cyc", 32'(a2), 32'(c + 1));
        check("abort_count", 32'(count), 32'd1);
        wait_resp(1);
        check("abort_resp_cyc", 32'(rs_cyc[0]), 32'(a2 + 2));
        check("abort_resp_ok", 32'(rs_ok[0]), 32'd1);
        check("abort_start_in", st_in[st_in.size() - 1], 32'h66);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
